// File: rtl/pp_pkg.sv
// Path Parser shared definitions: path-word field ranges, hop types, HOP_INFO layout
// and the hop-extract FSM states.
package pp_pkg;

  localparam int PP_META_RCI_NBITS = 16;
  localparam int INITIAL_HOP       = 0;

  // Header word: {rci[31:16], hop_cnt[15:8], cur_ptr[7:0]}
  localparam int HDR_RCI_MSB = 31;
  localparam int HDR_RCI_LSB = 16;
  localparam int HDR_PTR_MSB = 7;
  localparam int HDR_PTR_LSB = 0;

  // Hop word: {type[31:29], rsvd[28:16], rci[15:0]}
  localparam int HOP_TYPE_MSB = 31;
  localparam int HOP_TYPE_LSB = 29;
  localparam int HOP_RCI_MSB  = 15;
  localparam int HOP_RCI_LSB  = 0;

  typedef enum logic [2:0] {
    HOP_NULL                 = 3'd0,
    HOP_START_PROCESS        = 3'd1,
    HOP_END_PROCESS          = 3'd2,
    HOP_START_THREAD_PROCESS = 3'd3,
    HOP_END_THREAD_PROCESS   = 3'd4
  } hop_type_e;

  typedef struct packed {
    logic [2:0]  hop_type;
    logic [15:0] rci;
    logic [7:0]  byte_ptr;
  } hop_info_t;

  localparam int HOP_INFO_NBITS = $bits(hop_info_t);

  typedef enum logic [1:0] {IDLE, SKIP, FILL, DRAIN} pp_state_e;

endpackage

// File: rtl/pp_hop_side_track.sv
// Ownership flag for one ping-pong hop FIFO: BUSY from header accept until pp_sm
// reports parse_done; the FIFO clear pulse coincides with the header accept.
module pp_hop_side_track (
  input  logic clk,
  input  logic rst,
  input  logic hdr_acc,
  input  logic parse_done,
  output logic busy,
  output logic fifo_reset
);

  // The top only accepts a header on a FREE side, so a header accept here always wins.
  always_ff @(posedge clk) begin
    if (rst)             busy <= 1'b0;
    else if (hdr_acc)    busy <= 1'b1;
    else if (parse_done) busy <= 1'b0;
  end

  assign fifo_reset = hdr_acc;

endmodule

// File: rtl/pp_hop_extract.sv
// Path Parser front end: emits the target RCI per packet and streams the relevant hop
// descriptors into pp_sm's ping-pong hop FIFOs, alternating FIFO per packet.
module pp_hop_extract
  import pp_pkg::*;
#(
  parameter int IN_W           = 32,
  parameter int HOP_FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         path_valid,
  output logic                         path_ready,
  input  logic                         path_sop,
  input  logic                         path_eop,
  input  logic [IN_W-1:0]              path_data,
  output logic                         pp_meta_valid,
  output logic [PP_META_RCI_NBITS-1:0] pp_meta_rci,
  output logic                         hop_fifo_reset0,
  output logic                         hop_fifo_reset1,
  output logic                         hop_fifo_wr0,
  output logic                         hop_fifo_wr1,
  output logic [HOP_INFO_NBITS-1:0]    hop_fifo_wdata0,
  output logic [HOP_INFO_NBITS-1:0]    hop_fifo_wdata1,
  input  logic                         hop_fifo_full0,
  input  logic                         hop_fifo_full1,
  input  logic                         parse_done0,
  input  logic                         parse_done1
);

  if (HOP_FIFO_DEPTH != 4) begin : g_depth_chk
    $error("pp_hop_extract: HOP_FIFO_DEPTH must match pp_sm FIFO_DEPTH_NBITS=2");
  end

  localparam logic [7:0] FIRST_IDX = 8'(INITIAL_HOP);

  pp_state_e  state_q, state_d;
  logic       wsel_q, wsel_d;
  logic [7:0] idx_q, start_q, cur_ptr, hdr_start;
  logic [1:0] busy;
  logic       ready, hdr_acc, hop_acc, hop_wr;
  logic       hdr_go, wr_go, full_sel, done_sel;
  hop_info_t  info;

  // Byte offset of hop idx, clamped to the byte_ptr field maximum.
  function automatic logic [7:0] sat_byte_ptr(input logic [7:0] idx);
    logic [9:0] bp;
    bp = {idx, 2'b00};
    return (bp > 10'd255) ? 8'hFF : bp[7:0];
  endfunction

  assign cur_ptr   = path_data[HDR_PTR_MSB:HDR_PTR_LSB];
  assign hdr_start = (cur_ptr == 8'd0) ? 8'd0 : cur_ptr - 8'd1;
  assign full_sel  = wsel_q ? hop_fifo_full1 : hop_fifo_full0;
  assign done_sel  = wsel_q ? parse_done1 : parse_done0;

  always_comb begin
    state_d = state_q;
    wsel_d  = wsel_q;
    ready   = 1'b0;
    hdr_acc = 1'b0;
    hop_acc = 1'b0;
    hop_wr  = 1'b0;
    if (state_q == IDLE) begin
      // Stray non-sop words are dropped; a header waits for its side to be FREE.
      ready = path_sop ? ~busy[wsel_q] : 1'b1;
      if (path_valid && path_sop && !busy[wsel_q]) begin
        hdr_acc = 1'b1;
        if (path_eop) wsel_d  = ~wsel_q;
        else          state_d = (hdr_start == FIRST_IDX) ? FILL : SKIP;
      end
    end else if (path_valid && path_sop) begin
      // Premature header closes the current packet; the word is re-evaluated in IDLE.
      state_d = IDLE;
      wsel_d  = ~wsel_q;
    end else begin
      ready   = (state_q == FILL) ? ~full_sel : 1'b1;
      hop_acc = path_valid & ready;
      hop_wr  = hop_acc & (state_q == FILL) & ~done_sel;
      if (hop_acc && path_eop) begin
        state_d = IDLE;
        wsel_d  = ~wsel_q;
      end else if (state_q == FILL && done_sel) begin
        state_d = DRAIN;
      end else if (hop_acc && state_q == SKIP && (idx_q + 8'd1) == start_q) begin
        state_d = FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wsel_q  <= wsel_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hdr_acc) begin
      idx_q   <= FIRST_IDX;
      start_q <= hdr_start;
    end else if (hop_acc && idx_q != 8'hFF) begin
      idx_q <= idx_q + 8'd1;
    end
  end

  assign info = '{hop_type: path_data[HOP_TYPE_MSB:HOP_TYPE_LSB],
                  rci:      path_data[HOP_RCI_MSB:HOP_RCI_LSB],
                  byte_ptr: sat_byte_ptr(idx_q)};

  assign hdr_go = hdr_acc & ~rst;
  assign wr_go  = hop_wr & ~rst;

  assign path_ready      = ready & ~rst;
  assign pp_meta_valid   = hdr_go;
  assign pp_meta_rci     = hdr_go ? path_data[HDR_RCI_MSB:HDR_RCI_LSB] : '0;
  assign hop_fifo_wr0    = wr_go & ~wsel_q;
  assign hop_fifo_wr1    = wr_go & wsel_q;
  assign hop_fifo_wdata0 = hop_fifo_wr0 ? info : '0;
  assign hop_fifo_wdata1 = hop_fifo_wr1 ? info : '0;

  pp_hop_side_track u_side0 (
    .clk        (clk),
    .rst        (rst),
    .hdr_acc    (hdr_go & ~wsel_q),
    .parse_done (parse_done0),
    .busy       (busy[0]),
    .fifo_reset (hop_fifo_reset0)
  );

  pp_hop_side_track u_side1 (
    .clk        (clk),
    .rst        (rst),
    .hdr_acc    (hdr_go & wsel_q),
    .parse_done (parse_done1),
    .busy       (busy[1]),
    .fifo_reset (hop_fifo_reset1)
  );

endmodule

// File: tb/tb_pp_hop_extract.sv
// Directed bench for pp_hop_extract: per-scenario tasks with hand-computed expectations.
module tb_pp_hop_extract;
  import pp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rst, path_valid, path_ready, path_sop, path_eop;
  logic [31:0]                  path_data;
  logic                         pp_meta_valid;
  logic [PP_META_RCI_NBITS-1:0] pp_meta_rci;
  logic                         hop_fifo_reset0, hop_fifo_reset1, hop_fifo_wr0, hop_fifo_wr1;
  logic [HOP_INFO_NBITS-1:0]    hop_fifo_wdata0, hop_fifo_wdata1;
  logic                         hop_fifo_full0, hop_fifo_full1, parse_done0, parse_done1;

  pp_hop_extract #(.IN_W(32), .HOP_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .path_valid(path_valid), .path_ready(path_ready),
    .path_sop(path_sop), .path_eop(path_eop), .path_data(path_data),
    .pp_meta_valid(pp_meta_valid), .pp_meta_rci(pp_meta_rci),
    .hop_fifo_reset0(hop_fifo_reset0), .hop_fifo_reset1(hop_fifo_reset1),
    .hop_fifo_wr0(hop_fifo_wr0), .hop_fifo_wr1(hop_fifo_wr1),
    .hop_fifo_wdata0(hop_fifo_wdata0), .hop_fifo_wdata1(hop_fifo_wdata1),
    .hop_fifo_full0(hop_fifo_full0), .hop_fifo_full1(hop_fifo_full1),
    .parse_done0(parse_done0), .parse_done1(parse_done1)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stall_cnt;
  logic [HOP_INFO_NBITS-1:0] w0_q[$], w1_q[$];
  int w0_cyc[$], r0_cyc[$], r1_cyc[$];
  logic [15:0] meta_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (hop_fifo_wr0) begin w0_q.push_back(hop_fifo_wdata0); w0_cyc.push_back(cyc); end
    if (hop_fifo_wr1) w1_q.push_back(hop_fifo_wdata1);
    if (hop_fifo_reset0) r0_cyc.push_back(cyc);
    if (hop_fifo_reset1) r1_cyc.push_back(cyc);
    if (pp_meta_valid) meta_q.push_back(pp_meta_rci);
    if (path_valid && !path_ready) stall_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] hdr_w(input logic [15:0] rci, input logic [7:0] cnt,
                                        input logic [7:0] ptr);
    return {rci, cnt, ptr};
  endfunction

  function automatic logic [31:0] hop_w(input logic [2:0] t, input logic [15:0] rci);
    return {t, 13'd0, rci};
  endfunction

  function automatic logic [HOP_INFO_NBITS-1:0] info_w(input logic [2:0] t,
                                                      input logic [15:0] rci, input logic [7:0] bp);
    return {t, rci, bp};
  endfunction

  task automatic clear_mon();
    w0_q.delete(); w1_q.delete(); w0_cyc.delete(); r0_cyc.delete(); r1_cyc.delete();
    meta_q.delete(); stall_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; path_valid = 1'b0; path_sop = 1'b0; path_eop = 1'b0; path_data = '0;
    hop_fifo_full0 = 1'b0; hop_fifo_full1 = 1'b0; parse_done0 = 1'b0; parse_done1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic send(input logic sop, input logic eop, input logic [31:0] d);
    int n;
    logic acc;
    n = 0; acc = 1'b0;
    path_valid = 1'b1; path_sop = sop; path_eop = eop; path_data = d;
    while (!acc && n < 200) begin
      @(negedge clk); acc = path_ready;
      @(posedge clk); #1; n++;
    end
    path_valid = 1'b0; path_sop = 1'b0; path_eop = 1'b0;
    if (!acc) begin
      n_assert++; n_fail++;
      $display("FAIL send_timeout: word %h not accepted, ready=%b required 1", d, acc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; path_valid = 1'b1; path_sop = 1'b1; path_eop = 1'b0;
    path_data = hdr_w(16'h0AAA, 8'd1, 8'd0);
    hop_fifo_full0 = 1'b0; hop_fifo_full1 = 1'b0; parse_done0 = 1'b0; parse_done1 = 1'b0;
    @(negedge clk);
    n_assert++; if (path_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", path_ready); end
    n_assert++; if (pp_meta_valid !== 1'b0 || pp_meta_rci !== 16'h0) begin n_fail++; $display("FAIL reset_meta: got %b/%h want 0/0000", pp_meta_valid, pp_meta_rci); end
    n_assert++; if ({hop_fifo_reset0, hop_fifo_reset1, hop_fifo_wr0, hop_fifo_wr1} !== 4'b0) begin n_fail++; $display("FAIL reset_fifo_ctl: got %b want 0000", {hop_fifo_reset0, hop_fifo_reset1, hop_fifo_wr0, hop_fifo_wr1}); end
    n_assert++; if (hop_fifo_wdata0 !== '0 || hop_fifo_wdata1 !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h/%h want 0/0", hop_fifo_wdata0, hop_fifo_wdata1); end
    @(posedge clk); #1;
    rst = 1'b0; path_valid = 1'b0;
    @(negedge clk);
    n_assert++; if (path_ready !== 1'b1) begin n_fail++; $display("FAIL reset_idle_ready: got %b want 1", path_ready); end
    @(posedge clk); #1;
    path_sop = 1'b0;
  endtask

  task automatic test_basic();
    logic [2:0] t3[3];
    logic [HOP_INFO_NBITS-1:0] got, exp;
    t3 = '{HOP_START_PROCESS, HOP_NULL, HOP_END_PROCESS};
    do_reset();
    send(1'b1, 1'b0, hdr_w(16'h0123, 8'd3, 8'd0));
    for (int i = 0; i < 3; i++) send(1'b0, i == 2, hop_w(t3[i], 16'h000A + 16'(i)));
    send(1'b1, 1'b1, hdr_w(16'h0456, 8'd0, 8'd0));
    @(posedge clk); #1;
    n_assert++; if (w0_q.size() !== 3) begin n_fail++; $display("FAIL basic_w0_count: got %0d want 3", w0_q.size()); end
    for (int i = 0; i < 3; i++) begin
      exp = info_w(t3[i], 16'h000A + 16'(i), 8'(4 * i));
      got = (i < w0_q.size()) ? w0_q[i] : 'x;
      n_assert++; if (got !== exp) begin n_fail++; $display("FAIL basic_w0[%0d]: got %h want %h", i, got, exp); end
    end
    n_assert++; if (meta_q.size() !== 2 || meta_q[0] !== 16'h0123 || meta_q[1] !== 16'h0456) begin n_fail++; $display("FAIL basic_meta: got %0d entries want 2 (0123,0456)", meta_q.size()); end
    n_assert++; if (r0_cyc.size() !== 1 || w0_cyc.size() == 0 || r0_cyc[0] >= w0_cyc[0]) begin n_fail++; $display("FAIL basic_reset0_order: got %0d pulses want 1 before first write", r0_cyc.size()); end
    n_assert++; if (r1_cyc.size() !== 1 || w1_q.size() !== 0) begin n_fail++; $display("FAIL basic_wsel_toggle: got reset1=%0d w1=%0d want 1/0", r1_cyc.size(), w1_q.size()); end
  endtask

  task automatic test_skip();
    logic [HOP_INFO_NBITS-1:0] got, exp;
    do_reset();
    send(1'b1, 1'b0, hdr_w(16'h0777, 8'd8, 8'd5));
    for (int i = 0; i < 8; i++) send(1'b0, i == 7, hop_w(HOP_NULL, 16'h0100 + 16'(i)));
    n_assert++; if (w0_q.size() !== 4) begin n_fail++; $display("FAIL skip_w0_count: got %0d want 4", w0_q.size()); end
    for (int i = 0; i < 4; i++) begin
      exp = info_w(HOP_NULL, 16'h0104 + 16'(i), 8'(16 + 4 * i));
      got = (i < w0_q.size()) ? w0_q[i] : 'x;
      n_assert++; if (got !== exp) begin n_fail++; $display("FAIL skip_w0[%0d]: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_full_stall();
    logic [HOP_INFO_NBITS-1:0] got, exp;
    do_reset();
    send(1'b1, 1'b0, hdr_w(16'h0900, 8'd10, 8'd0));
    for (int i = 0; i < 4; i++) send(1'b0, 1'b0, hop_w(HOP_START_THREAD_PROCESS, 16'h0200 + 16'(i)));
    hop_fifo_full0 = 1'b1;
    path_valid = 1'b1; path_data = hop_w(HOP_START_THREAD_PROCESS, 16'h0204);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_assert++; if (path_ready !== 1'b0 || hop_fifo_wr0 !== 1'b0) begin n_fail++; $display("FAIL full_stall[%0d]: got ready=%b wr0=%b want 0/0", k, path_ready, hop_fifo_wr0); end
      @(posedge clk); #1;
    end
    hop_fifo_full0 = 1'b0;
    for (int i = 4; i < 10; i++) send(1'b0, i == 9, hop_w(HOP_START_THREAD_PROCESS, 16'h0200 + 16'(i)));
    n_assert++; if (stall_cnt !== 3) begin n_fail++; $display("FAIL full_stall_cycles: got %0d want 3", stall_cnt); end
    n_assert++; if (w0_q.size() !== 10) begin n_fail++; $display("FAIL full_w0_count: got %0d want 10", w0_q.size()); end
    for (int i = 0; i < 10; i++) begin
      exp = info_w(HOP_START_THREAD_PROCESS, 16'h0200 + 16'(i), 8'(4 * i));
      got = (i < w0_q.size()) ? w0_q[i] : 'x;
      n_assert++; if (got !== exp) begin n_fail++; $display("FAIL full_w0[%0d]: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_parse_done_drain();
    logic [HOP_INFO_NBITS-1:0] got, exp;
    do_reset();
    send(1'b1, 1'b0, hdr_w(16'h0A00, 8'd10, 8'd0));
    for (int i = 0; i < 5; i++) send(1'b0, 1'b0, hop_w(HOP_NULL, 16'h0400 + 16'(i)));
    parse_done0 = 1'b1;
    @(posedge clk); #1;
    parse_done0 = 1'b0;
    for (int i = 5; i < 10; i++) send(1'b0, i == 9, hop_w(HOP_NULL, 16'h0400 + 16'(i)));
    send(1'b1, 1'b0, hdr_w(16'h0B00, 8'd1, 8'd0));
    send(1'b0, 1'b1, hop_w(HOP_END_PROCESS, 16'h0B01));
    n_assert++; if (w0_q.size() !== 5) begin n_fail++; $display("FAIL drain_w0_count: got %0d want 5", w0_q.size()); end
    n_assert++; if (r1_cyc.size() !== 1) begin n_fail++; $display("FAIL drain_next_reset1: got %0d want 1", r1_cyc.size()); end
    exp = info_w(HOP_END_PROCESS, 16'h0B01, 8'd0);
    got = (w1_q.size() == 1) ? w1_q[0] : 'x;
    n_assert++; if (got !== exp) begin n_fail++; $display("FAIL drain_next_w1: got %h want %h", got, exp); end
  endtask

  task automatic test_back_to_back();
    logic [HOP_INFO_NBITS-1:0] got, exp;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      send(1'b1, 1'b0, hdr_w(16'h0C01 + 16'(p), 8'd2, 8'd0));
      send(1'b0, 1'b0, hop_w(HOP_START_PROCESS, 16'h0C10 + 16'(p)));
      send(1'b0, 1'b1, hop_w(HOP_END_PROCESS, 16'h0C20 + 16'(p)));
    end
    path_valid = 1'b1; path_sop = 1'b1; path_data = hdr_w(16'h0C03, 8'd1, 8'd0);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) parse_done0 = 1'b1;
      @(negedge clk);
      n_assert++; if (path_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_hdr_stall[%0d]: got ready=%b want 0", k, path_ready); end
      @(posedge clk); #1;
    end
    parse_done0 = 1'b0;
    send(1'b1, 1'b0, hdr_w(16'h0C03, 8'd1, 8'd0));
    send(1'b0, 1'b1, hop_w(HOP_NULL, 16'h0C30));
    n_assert++; if (w0_q.size() !== 3 || w1_q.size() !== 2) begin n_fail++; $display("FAIL b2b_counts: got w0=%0d w1=%0d want 3/2", w0_q.size(), w1_q.size()); end
    n_assert++; if (r0_cyc.size() !== 2 || r1_cyc.size() !== 1) begin n_fail++; $display("FAIL b2b_resets: got r0=%0d r1=%0d want 2/1", r0_cyc.size(), r1_cyc.size()); end
    n_assert++; if (r0_cyc.size() < 2 || w0_cyc.size() < 3 || r0_cyc[1] >= w0_cyc[2]) begin n_fail++; $display("FAIL b2b_reset_order: reset0 pulse not before packet-3 write"); end
    exp = info_w(HOP_NULL, 16'h0C30, 8'd0);
    got = (w0_q.size() == 3) ? w0_q[2] : 'x;
    n_assert++; if (got !== exp) begin n_fail++; $display("FAIL b2b_p3_w0: got %h want %h", got, exp); end
    n_assert++; if (stall_cnt !== 5) begin n_fail++; $display("FAIL b2b_stall_cycles: got %0d want 5", stall_cnt); end
  endtask

  task automatic test_sop_mid();
    do_reset();
    send(1'b1, 1'b0, hdr_w(16'h0F00, 8'd4, 8'd0));
    send(1'b0, 1'b0, hop_w(HOP_NULL, 16'h0F10));
    send(1'b1, 1'b0, hdr_w(16'h0F01, 8'd1, 8'd0));
    send(1'b0, 1'b1, hop_w(HOP_END_PROCESS, 16'h0F11));
    n_assert++; if (stall_cnt !== 1) begin n_fail++; $display("FAIL sopmid_hold: got %0d stall cycles want 1", stall_cnt); end
    n_assert++; if (w0_q.size() !== 1 || w1_q.size() !== 1 || r1_cyc.size() !== 1) begin n_fail++; $display("FAIL sopmid_sides: got w0=%0d w1=%0d r1=%0d want 1/1/1", w0_q.size(), w1_q.size(), r1_cyc.size()); end
  endtask

  task automatic test_saturate();
    logic [7:0] bp_exp[4];
    logic [HOP_INFO_NBITS-1:0] got, exp;
    bp_exp = '{8'd248, 8'd252, 8'd255, 8'd255};
    do_reset();
    send(1'b1, 1'b0, hdr_w(16'h0300, 8'd66, 8'd0));
    for (int i = 0; i < 66; i++) send(1'b0, i == 65, hop_w(HOP_NULL, 16'h0300 + 16'(i)));
    n_assert++; if (w0_q.size() !== 66) begin n_fail++; $display("FAIL sat_w0_count: got %0d want 66", w0_q.size()); end
    for (int i = 0; i < 4; i++) begin
      exp = info_w(HOP_NULL, 16'h0300 + 16'(62 + i), bp_exp[i]);
      got = (62 + i < w0_q.size()) ? w0_q[62 + i] : 'x;
      n_assert++; if (got !== exp) begin n_fail++; $display("FAIL sat_w0[%0d]: got %h want %h", 62 + i, got, exp); end
    end
  endtask

  task automatic test_rst_in_fill();
    logic [HOP_INFO_NBITS-1:0] got, exp;
    do_reset();
    send(1'b1, 1'b0, hdr_w(16'h0D00, 8'd4, 8'd0));
    send(1'b0, 1'b0, hop_w(HOP_NULL, 16'h0D10));
    send(1'b0, 1'b0, hop_w(HOP_NULL, 16'h0D11));
    rst = 1'b1; path_valid = 1'b1; path_data = hop_w(HOP_NULL, 16'h0D12);
    @(negedge clk);
    n_assert++; if ({path_ready, hop_fifo_wr0, hop_fifo_wr1, pp_meta_valid, hop_fifo_reset0, hop_fifo_reset1} !== 6'b0) begin n_fail++; $display("FAIL rstfill_outputs: got %b want 000000", {path_ready, hop_fifo_wr0, hop_fifo_wr1, pp_meta_valid, hop_fifo_reset0, hop_fifo_reset1}); end
    n_assert++; if (hop_fifo_wdata0 !== '0) begin n_fail++; $display("FAIL rstfill_wdata0: got %h want 0", hop_fifo_wdata0); end
    @(posedge clk); #1;
    rst = 1'b0; path_valid = 1'b0;
    clear_mon();
    send(1'b1, 1'b0, hdr_w(16'h0E00, 8'd1, 8'd0));
    send(1'b0, 1'b1, hop_w(HOP_START_PROCESS, 16'h00E1));
    n_assert++; if (r0_cyc.size() !== 1 || r1_cyc.size() !== 0 || stall_cnt !== 0) begin n_fail++; $display("FAIL rstfill_next_side: got r0=%0d r1=%0d stalls=%0d want 1/0/0", r0_cyc.size(), r1_cyc.size(), stall_cnt); end
    exp = info_w(HOP_START_PROCESS, 16'h00E1, 8'd0);
    got = (w0_q.size() == 1) ? w0_q[0] : 'x;
    n_assert++; if (got !== exp) begin n_fail++; $display("FAIL rstfill_next_w0: got %h want %h", got, exp); end
  endtask

  initial begin
    stall_cnt = 0;
    test_reset();
    test_basic();
    test_skip();
    test_full_stall();
    test_parse_done_drain();
    test_back_to_back();
    test_sop_mid();
    test_saturate();
    test_rst_in_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
